// File: rtl/branch_resolve_unit.sv
// Registered branch resolver: compares operands, computes the redirect PC, flags mispredicts and flushes.
// Optional statistics counters are enabled with the BRU_STATS_EN macro.
module branch_resolve_unit #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic            pred_taken,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            taken,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic            illegal,
    output logic            flush
`ifdef BRU_STATS_EN
    ,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mispred_cnt
`endif
);

    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    if (FLUSH_CYCLES < 1 || CNT_W < 1 || (XLEN != 32 && XLEN != 64)) begin : gBadParams
        $error("branch_resolve_unit: unsupported parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESP  = 2'd1,
        FLUSH = 2'd2
    } stateT;

    stateT            state;
    stateT            stateNext;
    logic [FCW-1:0]   flushCnt;
    logic [FCW-1:0]   flushCntNext;
    logic             readyInt;
    logic             outValidInt;
    logic             flushInt;
    logic             acceptBranch;

    logic             isEq;
    logic             isLts;
    logic             isLtu;
    logic             takenNext;
    logic             illegalNext;
    logic [XLEN-1:0]  redirectNext;

    // Branch condition decode from the live operands; only sampled on accept.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
        takenNext   = 1'b0;
        illegalNext = 1'b0;
        isEq        = (rs1 == rs2);
        isLts       = ($signed(rs1) < $signed(rs2));
        isLtu       = (rs1 < rs2);
        case (funct3)
            3'b000:  takenNext = isEq;
            3'b001:  takenNext = !isEq;
            3'b100:  takenNext = isLts;
            3'b101:  takenNext = !isLts;
            3'b110:  takenNext = isLtu;
            3'b111:  takenNext = !isLtu;
            default: illegalNext = 1'b1;
        endcase
        // Both sums wrap modulo 2^XLEN by construction of the operand width.
        redirectNext = takenNext ? (pc + imm) : (pc + XLEN'(4));
    end

    // Next-state and handshake decode; flush depends on state only.
    always_comb begin
        stateNext    = state;
        flushCntNext = flushCnt;
        readyInt     = 1'b0;
        outValidInt  = 1'b0;
        flushInt     = 1'b0;
        case (state)
            IDLE: begin
                readyInt = 1'b1;
                if (in_valid) begin
                    stateNext = RESP;
                end
            end
            RESP: begin
                outValidInt = 1'b1;
                readyInt    = out_ready && !mispredict;
                if (out_ready) begin
                    if (mispredict) begin
                        stateNext    = FLUSH;
                        flushCntNext = FCW'(FLUSH_CYCLES - 1);
                    end else if (!in_valid) begin
                        stateNext = IDLE;
                    end
                end
            end
            FLUSH: begin
                flushInt = 1'b1;
                if (flushCnt == '0) begin
                    stateNext = IDLE;
                end else begin
                    flushCntNext = flushCnt - 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
        acceptBranch = in_valid && readyInt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state    <= IDLE;
            flushCnt <= '0;
        end else begin
            state    <= stateNext;
            flushCnt <= flushCntNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the result registers are reset even though they only matter while out_valid is high, so outputs are defined after reset.
        if (!rst_n) begin
            taken       <= 1'b0;
            mispredict  <= 1'b0;
            illegal     <= 1'b0;
            redirect_pc <= '0;
        end else if (acceptBranch) begin
            taken       <= takenNext;
            mispredict  <= takenNext ^ pred_taken;
            illegal     <= illegalNext;
            redirect_pc <= redirectNext;
        end
    end

    assign out_valid = outValidInt;
    assign flush     = flushInt;
    assign in_ready  = rst_n && readyInt;

`ifdef BRU_STATS_EN
    // Saturating counters: both stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt      <= '0;
            mispred_cnt <= '0;
        end else if (outValidInt && out_ready) begin
            if (br_cnt != '1) begin
                br_cnt <= br_cnt + 1'b1;
            end
            if (mispredict && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
